// File: rtl/core_mul_ext_pkg.sv
// Shared uarch types for the extended multiplier: operand words, decode and writeback
// records, multiply modes, and the helper that spreads partial products over stages.
package core_mul_ext_pkg;

   typedef logic [31:0] word;
   typedef logic [15:0] hword;
   typedef logic [3:0]  reg_idx;

   typedef enum logic [1:0] {
      MUL_LO  = 2'd0,
      MUL_HSS = 2'd1,
      MUL_HUU = 2'd2,
      MUL_HSU = 2'd3
   } mul_op;

   localparam int MUL_EXT_MAX_STAGES = 6;

   typedef struct packed {
      reg_idx rd;
      reg_idx rs1;
      reg_idx rs2;
   } insn_data;

   typedef struct packed {
      logic [6:0] opcode;
      insn_data   data;
   } insn_decode;

   typedef struct packed {
      reg_idx rd;
      word    value;
      logic   ready;
   } wb_line;

   // Accumulation step that absorbs partial product idx when npp products are
   // spread evenly over steps register stages.
   function automatic int pp_step(input int idx, input int npp, input int steps);
      return idx / ((npp + steps - 1) / steps);
   endfunction

endpackage

// File: rtl/core_mul_pp.sv
// LIMB x LIMB unsigned partial-product array plus high-word sign correction; combinational.
// No state and no backpressure: the caller registers the outputs.
module core_mul_pp
   import core_mul_ext_pkg::*;
#(
   parameter int LIMB = 8
) (
   input  mul_op                                                op,
   input  word                                                  a,
   input  word                                                  b,
   output logic [(32/LIMB)*(32/LIMB)-1:0][2*LIMB-1:0]           pp,
   output word                                                  corr
);

   localparam int N = 32 / LIMB;

   logic sa;
   logic sb;

   always_comb begin
      pp = '0;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            pp[i*N+j] = {{LIMB{1'b0}}, a[i*LIMB +: LIMB]} * {{LIMB{1'b0}}, b[j*LIMB +: LIMB]};
         end
      end
   end

   // A sign-extended operand is (x - 2^32) when its top bit is set, so the signed
   // product differs from the unsigned one only by subtracting the other operand at bit 32.
   assign sa   = a[31] && (op == MUL_HSS || op == MUL_HSU);
   assign sb   = b[31] && (op == MUL_HSS);
   assign corr = 32'd0 - (sa ? b : 32'd0) - (sb ? a : 32'd0);

endmodule

// File: rtl/core_raw_mask.sv
// One-hot hazard mask for a single pipeline slot; combinational, no backpressure.
// x0 never produces a hazard bit.
module core_raw_mask
   import core_mul_ext_pkg::*;
(
   input  logic   vld,
   input  reg_idx rd,
   output hword   mask
);

   assign mask = (vld && rd != '0) ? (hword'(1) << rd) : '0;

endmodule

// File: rtl/core_mul_ext.sv
// Pipelined 32x32 multiplier with LO/HSS/HUU/HSU modes; STAGES cycles issue to writeback.
// wb_stall holds the last stage and ripples back only through occupied stages; ab_stall holds issue.
module core_mul_ext
   import core_mul_ext_pkg::*;
#(
   parameter int LIMB        = 8,
   parameter int STAGES      = 4,
   parameter int OPERAND_REG = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  insn_decode dec,
   input  logic       start,
   input  mul_op      op,
   input  word        a,
   input  word        b,
   input  logic       wb_stall,
   input  logic       flush,
   output wb_line     wb,
   output hword       raw_mask,
   output logic       ab_stall
);

   localparam int N   = 32 / LIMB;
   localparam int NPP = N * N;
   localparam int P   = 1 + OPERAND_REG;
   localparam int M   = STAGES - OPERAND_REG;

   if (STAGES < 3 || STAGES > MUL_EXT_MAX_STAGES || (32 % LIMB) != 0 ||
       OPERAND_REG < 0 || OPERAND_REG > 1) begin : g_bad_param
      $error("core_mul_ext: illegal LIMB/STAGES/OPERAND_REG combination");
   end

   logic [STAGES:1] vld_q;
   logic [STAGES:1] vin;
   logic [STAGES:1] stall;
   reg_idx          rd_q [1:STAGES];
   mul_op           op_q [1:STAGES-1];
   word             val_q;

   word                         pp_a;
   word                         pp_b;
   mul_op                       pp_op;
   logic [NPP-1:0][2*LIMB-1:0]  pp_comb;
   word                         corr_comb;

   logic [NPP-1:0][2*LIMB-1:0]  pp_q   [M-1];
   logic [63:0]                 acc_q  [M-1];
   word                         corr_q [M-1];

   logic [63:0] fin_sum;
   word         fin_val;
   hword        masks [0:STAGES];
   logic        dec_unused;

   assign dec_unused = ^{dec.opcode, dec.data.rs1, dec.data.rs2};

   assign vin = {vld_q[STAGES-1:1], start};

   // Empty stages never stall, so a bubble ahead of a held stage is filled.
   always_comb begin
      stall         = '0;
      stall[STAGES] = wb_stall && vld_q[STAGES];
      for (int s = STAGES - 1; s >= 1; s--) begin
         stall[s] = stall[s+1] && vld_q[s];
      end
   end

   assign ab_stall = start && stall[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
      end else if (flush) begin
         vld_q <= '0;
      end else begin
         for (int s = 1; s <= STAGES; s++) begin
            if (!stall[s]) vld_q[s] <= vin[s];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!stall[1]) begin
         rd_q[1] <= dec.data.rd;
         op_q[1] <= op;
      end
      for (int s = 2; s <= STAGES; s++) begin
         if (!stall[s]) rd_q[s] <= rd_q[s-1];
      end
      for (int s = 2; s < STAGES; s++) begin
         if (!stall[s]) op_q[s] <= op_q[s-1];
      end
   end

   if (OPERAND_REG != 0) begin : g_opreg
      word a_q;
      word b_q;
      always_ff @(posedge clk) begin
         if (!stall[1]) begin
            a_q <= a;
            b_q <= b;
         end
      end
      assign pp_a  = a_q;
      assign pp_b  = b_q;
      assign pp_op = op_q[1];
   end else begin : g_noreg
      assign pp_a  = a;
      assign pp_b  = b;
      assign pp_op = op;
   end

   core_mul_pp #(.LIMB(LIMB)) u_pp (
      .op   (pp_op),
      .a    (pp_a),
      .b    (pp_b),
      .pp   (pp_comb),
      .corr (corr_comb)
   );

   // Accumulation stages: each folds its share of partial products into the running sum.
   for (genvar m = 0; m < M - 1; m++) begin : g_mid
      logic [NPP-1:0][2*LIMB-1:0] pp_src;
      logic [63:0]                acc_src;
      logic [63:0]                acc_nxt;
      word                        corr_src;

      if (m == 0) begin : g_head
         assign pp_src   = pp_comb;
         assign acc_src  = '0;
         assign corr_src = corr_comb;
      end else begin : g_body
         assign pp_src   = pp_q[m-1];
         assign acc_src  = acc_q[m-1];
         assign corr_src = corr_q[m-1];
      end

      always_comb begin
         acc_nxt = acc_src;
         for (int p = 0; p < NPP; p++) begin
            if (pp_step(p, NPP, M) == m) begin
               acc_nxt = acc_nxt + (64'(pp_src[p]) << (((p / N) + (p % N)) * LIMB));
            end
         end
      end

      always_ff @(posedge clk) begin
         if (!stall[P+m]) begin
            pp_q[m]   <= pp_src;
            acc_q[m]  <= acc_nxt;
            corr_q[m] <= corr_src;
         end
      end
   end

   // Recombination: last partial products, sign correction, then word select.
   always_comb begin
      fin_sum = acc_q[M-2] + {corr_q[M-2], 32'd0};
      for (int p = 0; p < NPP; p++) begin
         if (pp_step(p, NPP, M) == M - 1) begin
            fin_sum = fin_sum + (64'(pp_q[M-2][p]) << (((p / N) + (p % N)) * LIMB));
         end
      end
      fin_val = (op_q[STAGES-1] == MUL_LO) ? fin_sum[31:0] : fin_sum[63:32];
   end

   always_ff @(posedge clk) begin
      if (!stall[STAGES]) val_q <= fin_val;
   end

   assign wb = '{rd: rd_q[STAGES], value: val_q, ready: vld_q[STAGES]};

   for (genvar s = 0; s <= STAGES; s++) begin : g_raw
      if (s == 0) begin : g_issue
         core_raw_mask u_rm (.vld(start), .rd(dec.data.rd), .mask(masks[s]));
      end else begin : g_stage
         core_raw_mask u_rm (.vld(vld_q[s]), .rd(rd_q[s]), .mask(masks[s]));
      end
   end

   always_comb begin
      raw_mask = '0;
      for (int s = 0; s <= STAGES; s++) begin
         raw_mask = raw_mask | masks[s];
      end
   end

endmodule

// File: tb/tb_core_mul_ext.sv
// Scoreboard bench for core_mul_ext: main instance (LIMB 8, 4 stages) plus three
// alternate configurations exercised with the directed vectors.
module tb_core_mul_ext;
   import core_mul_ext_pkg::*;

   localparam int ST = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   insn_decode dec;
   logic       start;
   mul_op      op;
   word        a;
   word        b;
   logic       wb_stall;
   logic       flush;
   wb_line     wb;
   hword       raw_mask;
   logic       ab_stall;

   logic       aux_start;
   logic       aux_zero;
   wb_line     aux_wb  [3];
   hword       aux_rm  [3];
   logic       aux_abs [3];
   int         aux_st  [3] = '{3, 6, 3};

   typedef struct {
      reg_idx rd;
      word    val;
      int     due;
   } exp_t;

   exp_t sbq[$];
   exp_t mon_e;
   int   n_chk = 0;
   int   n_err = 0;
   int   cyc   = 0;
   bit   chk_lat = 1'b1;

   mul_op dir_op  [5] = '{MUL_LO, MUL_HSS, MUL_HUU, MUL_HSU, MUL_HSS};
   word   dir_a   [5] = '{32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
   word   dir_b   [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
   word   dir_exp [5] = '{32'hFFFF_FFFD, 32'h0000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h4000_0000};

   core_mul_ext #(.LIMB(8), .STAGES(ST), .OPERAND_REG(0)) dut (
      .clk(clk), .rst_n(rst_n), .dec(dec), .start(start), .op(op), .a(a), .b(b),
      .wb_stall(wb_stall), .flush(flush), .wb(wb), .raw_mask(raw_mask), .ab_stall(ab_stall)
   );

   core_mul_ext #(.LIMB(16), .STAGES(3), .OPERAND_REG(0)) u_aux0 (
      .clk(clk), .rst_n(rst_n), .dec(dec), .start(aux_start), .op(op), .a(a), .b(b),
      .wb_stall(aux_zero), .flush(aux_zero), .wb(aux_wb[0]), .raw_mask(aux_rm[0]), .ab_stall(aux_abs[0])
   );

   core_mul_ext #(.LIMB(16), .STAGES(6), .OPERAND_REG(1)) u_aux1 (
      .clk(clk), .rst_n(rst_n), .dec(dec), .start(aux_start), .op(op), .a(a), .b(b),
      .wb_stall(aux_zero), .flush(aux_zero), .wb(aux_wb[1]), .raw_mask(aux_rm[1]), .ab_stall(aux_abs[1])
   );

   core_mul_ext #(.LIMB(8), .STAGES(3), .OPERAND_REG(1)) u_aux2 (
      .clk(clk), .rst_n(rst_n), .dec(dec), .start(aux_start), .op(op), .a(a), .b(b),
      .wb_stall(aux_zero), .flush(aux_zero), .wb(aux_wb[2]), .raw_mask(aux_rm[2]), .ab_stall(aux_abs[2])
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic expect_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic word ref_mul(input mul_op o, input word x, input word y);
      logic [63:0] xa;
      logic [63:0] ya;
      logic [63:0] p;
      xa = (o == MUL_HSS || o == MUL_HSU) ? {{32{x[31]}}, x} : {32'd0, x};
      ya = (o == MUL_HSS) ? {{32{y[31]}}, y} : {32'd0, y};
      p  = xa * ya;
      return (o == MUL_LO) ? p[31:0] : p[63:32];
   endfunction

   // Entered just after a rising edge; returns just after the accepting edge.
   task automatic issue(input mul_op o, input word x, input word y, input reg_idx r,
                        input bit track, input word expv);
      int waited = 0;
      start       = 1'b1;
      op          = o;
      a           = x;
      b           = y;
      dec.data.rd = r;
      @(negedge clk);
      while (ab_stall && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (ab_stall) expect_eq("accept_timeout", 64'(ab_stall), 64'd0);
      if (track) sbq.push_back('{rd: r, val: expv, due: chk_lat ? cyc + ST : -1});
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sbq.size() != 0 && n < 60) begin
         @(posedge clk);
         n++;
      end
      expect_eq("drain_empty", 64'(sbq.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (rst_n && wb.ready && !wb_stall) begin
         expect_eq("ready_has_op", 64'(sbq.size() != 0), 64'd1);
         if (sbq.size() != 0) begin
            mon_e = sbq.pop_front();
            expect_eq("wb_rd", 64'(wb.rd), 64'(mon_e.rd));
            expect_eq("wb_value", 64'(wb.value), 64'(mon_e.val));
            if (mon_e.due >= 0) expect_eq("latency", 64'(cyc), 64'(mon_e.due));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1);
   end

   initial begin
      mul_op  o5;
      word    x5, y5, held;
      int     t_acc;
      bit [2:0] seen;

      rst_n = 1'b0; start = 1'b0; dec = '0; op = MUL_LO; a = '0; b = '0;
      wb_stall = 1'b0; flush = 1'b0; aux_start = 1'b0; aux_zero = 1'b0;

      #12;
      expect_eq("rst_ready", 64'(wb.ready), 64'd0);
      expect_eq("rst_raw_mask", 64'(raw_mask), 64'd0);
      expect_eq("rst_ab_stall", 64'(ab_stall), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed vectors back to back, exact latency each.
      for (int i = 0; i < 5; i++) issue(dir_op[i], dir_a[i], dir_b[i], reg_idx'(i + 1), 1'b1, dir_exp[i]);
      drain();

      // Eight back-to-back random ops, rd 1..8.
      for (int i = 1; i <= 8; i++) begin
         mul_op o;
         word   x, y;
         o = mul_op'($urandom_range(0, 3));
         x = $urandom();
         y = $urandom();
         issue(o, x, y, reg_idx'(i), 1'b1, ref_mul(o, x, y));
      end
      drain();

      // Writeback stall with a full pipe and a fifth op waiting at issue.
      chk_lat  = 1'b0;
      wb_stall = 1'b1;
      held     = '0;
      for (int i = 0; i < 4; i++) begin
         mul_op o;
         word   x, y;
         o = mul_op'($urandom_range(0, 3));
         x = $urandom();
         y = $urandom();
         if (i == 0) held = ref_mul(o, x, y);
         issue(o, x, y, reg_idx'(9 + i), 1'b1, ref_mul(o, x, y));
      end
      o5 = MUL_HUU; x5 = $urandom(); y5 = $urandom();
      start = 1'b1; op = o5; a = x5; b = y5; dec.data.rd = 4'd13;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         expect_eq("stall_ab_stall", 64'(ab_stall), 64'd1);
         expect_eq("stall_ready", 64'(wb.ready), 64'd1);
         expect_eq("stall_value_hold", 64'(wb.value), 64'(held));
         expect_eq("stall_rd_hold", 64'(wb.rd), 64'd9);
         expect_eq("stall_raw_mask", 64'(raw_mask), 64'h3E00);
      end
      @(posedge clk); #1;
      wb_stall = 1'b0;
      issue(o5, x5, y5, 4'd13, 1'b1, ref_mul(o5, x5, y5));
      drain();
      chk_lat = 1'b1;

      // Flush with three ops in flight and a fourth issuing in the same cycle.
      for (int i = 1; i <= 3; i++) issue(MUL_LO, $urandom(), $urandom(), reg_idx'(i), 1'b0, '0);
      start = 1'b1; op = MUL_HUU; a = $urandom(); b = $urandom(); dec.data.rd = 4'd4;
      flush = 1'b1;
      @(negedge clk);
      expect_eq("flush_cycle_raw_mask", 64'(raw_mask), 64'h001E);
      @(posedge clk); #1;
      flush = 1'b0;
      start = 1'b0;
      @(negedge clk);
      expect_eq("post_flush_raw_mask", 64'(raw_mask), 64'd0);
      expect_eq("post_flush_ready", 64'(wb.ready), 64'd0);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         expect_eq("flushed_no_ready", 64'(wb.ready), 64'd0);
      end
      @(posedge clk); #1;
      issue(MUL_HSU, 32'hFFFF_FFFF, 32'h0000_0010, 4'd5, 1'b1, 32'hFFFF_FFFF);
      drain();

      // Asynchronous reset while a result is held at writeback.
      wb_stall = 1'b1;
      issue(MUL_LO, 32'd5, 32'd9, 4'd7, 1'b0, '0);
      repeat (ST - 1) @(posedge clk);
      #2;
      expect_eq("pre_reset_ready", 64'(wb.ready), 64'd1);
      rst_n = 1'b0;
      #1;
      expect_eq("async_reset_ready", 64'(wb.ready), 64'd0);
      expect_eq("async_reset_raw_mask", 64'(raw_mask), 64'd0);
      @(posedge clk); #1;
      rst_n    = 1'b1;
      wb_stall = 1'b0;
      @(posedge clk); #1;
      issue(MUL_LO, 32'd7, 32'd6, 4'd3, 1'b1, 32'd42);
      drain();

      // Directed vectors on the alternate configurations.
      for (int v = 0; v < 5; v++) begin
         aux_start = 1'b1; op = dir_op[v]; a = dir_a[v]; b = dir_b[v]; dec.data.rd = 4'd2;
         t_acc = cyc;
         seen  = '0;
         @(posedge clk); #1;
         aux_start = 1'b0;
         for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            for (int j = 0; j < 3; j++) begin
               if (aux_wb[j].ready && !seen[j]) begin
                  seen[j] = 1'b1;
                  expect_eq($sformatf("aux%0d_v%0d_value", j, v), 64'(aux_wb[j].value), 64'(dir_exp[v]));
                  expect_eq($sformatf("aux%0d_v%0d_latency", j, v), 64'(cyc - t_acc), 64'(aux_st[j]));
               end
            end
         end
         expect_eq($sformatf("aux_v%0d_all_done", v), 64'(seen), 64'h7);
         @(posedge clk); #1;
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/core_mul_ext.md
Name: core_mul_ext

Overview:
Parametrised pipelined integer multiplier, the successor to the fixed 4-stage unsigned low-word multiplier. It adds four result modes: low word, signed high, unsigned high and signed×unsigned high. It also adds configurable limb width and pipeline depth, plus a flush. It sits beside the other execution units, takes decoded operands at issue, and writes back through the shared wb_line/raw_mask scheme.

Parameters:
LIMB, 8, limb width in bits for partial products; must divide 32 (legal: 8, 16).
STAGES, 4, total pipeline latency in cycles; legal 3..6.
OPERAND_REG, 0, if 1, a and b are registered before the partial-product stage; this register counts as one of the STAGES.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
dec  in  insn_decode  decoded instruction; only dec.data.rd is used
start  in  1  operands valid this cycle
op  in  mul_op  MUL_LO, MUL_HSS, MUL_HUU, MUL_HSU
a  in  word  multiplicand (rs1)
b  in  word  multiplier (rs2)
wb_stall  in  1  writeback port not accepting this cycle
flush  in  1  kill every in-flight operation
wb  out  wb_line  rd, value, ready
raw_mask  out  hword  OR of one-hot rd masks of all valid stages, including stage 0 when start=1
ab_stall  out  1  issue must hold operands (start && stage-1 stalled)

Behaviour:
- Reset (async, rst_n=0): all stage valid bits and wb.ready = 0. raw_mask = 0 and ab_stall = 0 once start=0. Datapath registers are not reset.
- Product: form a 33-bit extended operand for each of a and b.
  - Sign-extend when the mode treats the operand as signed: a for HSS/HSU, b for HSS only.
  - Otherwise zero-extend.
- Compute the 66-bit product. Result = bits[31:0] for MUL_LO, bits[63:32] otherwise.
- Partial products are LIMB×LIMB and accumulate across the stages. The sign correction term is added in the recombination stages.
- Latency: an op accepted at cycle t (start=1, ab_stall=0) gives wb.ready=1 with its value at cycle t+STAGES, provided no stall occurs.
- Throughput: one op per cycle.
- rd and op travel with the data through every stage.
- Stall chain:
  - stall_last = wb_stall && ready.
  - stall_k = stall_{k+1} && valid_k.
  - A stalled stage holds its data and valid bit.
  - An empty stage never stalls, so bubbles collapse.
- wb.ready stays 1 and wb.value stays stable for as long as wb_stall=1.
- flush: synchronous. On the next edge all valid bits, including ready, clear regardless of any stall.
  - If start=1 in the same cycle as flush, that op is dropped.
  - raw_mask contributions from dropped ops disappear the cycle after flush.
- Stall with start and wb_stall asserted and the pipe full: ab_stall=1 and the op is not accepted. Acceptance happens in the first cycle ab_stall=0.
- rd=0 is carried normally. core_raw_mask decides its mask bit.
- Illegal parameters (STAGES outside 3..6, or LIMB not dividing 32) fail elaboration via $error.

Decomposition:
- The shared uarch package gets the typedef enum logic[1:0] mul_op {MUL_LO, MUL_HSS, MUL_HUU, MUL_HSU} and the constant MUL_EXT_MAX_STAGES = 6.
- core_raw_mask is instantiated per stage in a generate loop.
- One sub-module: core_mul_pp. It is the combinational LIMB-parametrised partial-product array plus sign-correction terms feeding the first register stage.
- The pipeline and stall logic stay in core_mul_ext.

Test Plan:
- MUL_LO, a=0x00000003, b=0xFFFFFFFF, STAGES=4 -> wb.value=0xFFFFFFFD, wb.ready exactly 4 cycles after acceptance.
- MUL_HSS a=0xFFFFFFFF, b=0xFFFFFFFF -> 0x00000000; MUL_HUU same operands -> 0xFFFFFFFE; MUL_HSU same -> 0xFFFFFFFF; MUL_HSS a=0x80000000, b=0x80000000 -> 0x40000000.
- Back-to-back starts for 8 cycles with rd=1..8 and random operands -> 8 consecutive ready cycles, in order, values matching a 64-bit reference model.
- Hold wb_stall=1 for 5 cycles with 4 ops in flight -> wb value stable, ab_stall=1 once the pipe is full, no op lost or duplicated, raw_mask covers all 4 rds.
- Assert flush with 3 ops in flight and start=1 -> no ready afterwards, raw_mask=0 next cycle, an op started the following cycle completes normally.
- Assert rst_n=0 mid-operation -> wb.ready=0 asynchronously; after release the first new op completes with correct latency. Repeat the directed values with LIMB=16, STAGES=3 and STAGES=6.
